// File: rtl/tlc_pkg.sv
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared constants for the traffic phase controller: mode codes,
//            phase identifiers and one-hot {R,Y,G} lamp encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

  // Operating modes carried on mode_sel
  localparam logic [1:0] c_MODE_FIXED    = 2'b00;
  localparam logic [1:0] c_MODE_ACTUATED = 2'b01;
  localparam logic [1:0] c_MODE_FLASH    = 2'b10;
  localparam logic [1:0] c_MODE_ALL_STOP = 2'b11;

  // Phase identifiers, also the encoding presented on phase_id
  typedef enum logic [3:0] {
    PH_NS_GREEN  = 4'd0,
    PH_NS_YELLOW = 4'd1,
    PH_ALLRED_A  = 4'd2,
    PH_EW_GREEN  = 4'd3,
    PH_EW_YELLOW = 4'd4,
    PH_ALLRED_B  = 4'd5,
    PH_FLASH     = 4'd6,
    PH_ALL_STOP  = 4'd7
  } phase_e;

  // One-hot lamp drive {R,Y,G}; all-zero means the head is dark
  localparam logic [2:0] c_LIGHT_R    = 3'b100;
  localparam logic [2:0] c_LIGHT_Y    = 3'b010;
  localparam logic [2:0] c_LIGHT_G    = 3'b001;
  localparam logic [2:0] c_LIGHT_DARK = 3'b000;

  // True for either approach's green phase
  function automatic logic is_green(input phase_e p);
    return (p == PH_NS_GREEN) || (p == PH_EW_GREEN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_sync2.sv
// ============================================================================
// Module   : tlc_sync2
// Brief    : Two-flop synchronizer for an asynchronous detector level.
//            Output follows the input with two clk cycles of latency and
//            clears to 0 while rst_n is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture to resolve metastability on the detector input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/traffic_phase_fsm.sv
// ============================================================================
// Module   : traffic_phase_fsm
// Brief    : Two-approach intersection phase sequencer with fixed-time,
//            actuated (detector extended green), flash and all-stop modes.
//            Optional macro TLC_SENSOR_SYNC_EN inserts 2-flop synchronizers
//            on veh_ns / veh_ew; when undefined the detectors are used raw.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_fsm
  import tlc_pkg::*;
#(
  parameter int unsigned T_GREEN     = 30,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 2,
  parameter int unsigned T_MIN_GREEN = 10,
  parameter int unsigned T_EXT       = 5,
  parameter int unsigned T_MAX_GREEN = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] mode_sel,
  input  logic       veh_ns,
  input  logic       veh_ew,
  output logic [3:0] phase_id,
  output logic [7:0] time_left,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       phase_done
);

  localparam logic [7:0] c_T_GREEN     = 8'(T_GREEN);
  localparam logic [7:0] c_T_YELLOW    = 8'(T_YELLOW);
  localparam logic [7:0] c_T_ALLRED    = 8'(T_ALLRED);
  localparam logic [7:0] c_T_MIN_GREEN = 8'(T_MIN_GREEN);
  localparam logic [7:0] c_T_EXT       = 8'(T_EXT);
  localparam logic [8:0] c_T_EXT9      = 9'(T_EXT);
  localparam logic [8:0] c_T_MAX9      = 9'(T_MAX_GREEN);

  logic w_veh_ns;
  logic w_veh_ew;

`ifdef TLC_SENSOR_SYNC_EN
  tlc_sync2 u_sync_ns (.clk(clk), .rst_n(rst_n), .d_i(veh_ns), .q_o(w_veh_ns));
  tlc_sync2 u_sync_ew (.clk(clk), .rst_n(rst_n), .d_i(veh_ew), .q_o(w_veh_ew));
`else
  assign w_veh_ns = veh_ns;
  assign w_veh_ew = veh_ew;
`endif

  phase_e     phase_q,   phase_d;
  logic [7:0] time_q,    time_d;
  logic [7:0] elapsed_q, elapsed_d;
  logic       flash_y_q, flash_y_d;
  logic       done_q,    done_d;

  logic [7:0] w_green_len;
  logic [7:0] w_elapsed_inc;
  logic       w_req;
  logic       w_can_extend;

  // State register; reset parks the controller in all-red clearance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_ALLRED_B;
      time_q    <= c_T_ALLRED;
      elapsed_q <= 8'd0;
      flash_y_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      time_q    <= time_d;
      elapsed_q <= elapsed_d;
      flash_y_q <= flash_y_d;
      done_q    <= done_d;
    end
  end

  // Next-state: forced modes win over the tick, then normal ring timing
  always_comb begin
    phase_d       = phase_q;
    time_d        = time_q;
    elapsed_d     = elapsed_q;
    flash_y_d     = flash_y_q;
    w_green_len   = (mode_sel == c_MODE_ACTUATED) ? c_T_MIN_GREEN : c_T_GREEN;
    w_elapsed_inc = (elapsed_q == 8'hFF) ? 8'hFF : elapsed_q + 8'd1;
    w_req         = (phase_q == PH_EW_GREEN) ? w_veh_ew : w_veh_ns;
    // Extension is judged on ticks served including the expiring one
    w_can_extend  = (mode_sel == c_MODE_ACTUATED) && w_req &&
                    (({1'b0, w_elapsed_inc} + c_T_EXT9) <= c_T_MAX9);

    if (mode_sel == c_MODE_FLASH) begin
      if (phase_q != PH_FLASH) begin
        phase_d   = PH_FLASH;
        time_d    = 8'd0;
        flash_y_d = 1'b1;
      end else if (tick) begin
        flash_y_d = ~flash_y_q;
      end
    end else if (mode_sel == c_MODE_ALL_STOP) begin
      if (phase_q != PH_ALL_STOP) begin
        phase_d = PH_ALL_STOP;
        time_d  = 8'd0;
      end
    end else if ((phase_q == PH_FLASH) || (phase_q == PH_ALL_STOP)) begin
      // Recovery from a forced mode always re-enters through clearance
      phase_d = PH_ALLRED_B;
      time_d  = c_T_ALLRED;
    end else if (tick) begin
      if (is_green(phase_q)) begin
        elapsed_d = w_elapsed_inc;
      end
      if (time_q != 8'd1) begin
        time_d = time_q - 8'd1;
      end else begin
        case (phase_q)
          PH_NS_GREEN, PH_EW_GREEN: begin
            if (w_can_extend) begin
              time_d = c_T_EXT;
            end else begin
              phase_d = (phase_q == PH_NS_GREEN) ? PH_NS_YELLOW : PH_EW_YELLOW;
              time_d  = c_T_YELLOW;
            end
          end
          PH_NS_YELLOW: begin
            phase_d = PH_ALLRED_A;
            time_d  = c_T_ALLRED;
          end
          PH_ALLRED_A: begin
            phase_d   = PH_EW_GREEN;
            time_d    = w_green_len;
            elapsed_d = 8'd0;
          end
          PH_EW_YELLOW: begin
            phase_d = PH_ALLRED_B;
            time_d  = c_T_ALLRED;
          end
          PH_ALLRED_B: begin
            phase_d   = PH_NS_GREEN;
            time_d    = w_green_len;
            elapsed_d = 8'd0;
          end
          default: begin
            phase_d = phase_q;
          end
        endcase
      end
    end

    done_d = (phase_d != phase_q);
  end

  // Lamp decode from the registered phase and flash toggle
  always_comb begin
    ns_light = c_LIGHT_R;
    ew_light = c_LIGHT_R;
    case (phase_q)
      PH_NS_GREEN:  ns_light = c_LIGHT_G;
      PH_NS_YELLOW: ns_light = c_LIGHT_Y;
      PH_EW_GREEN:  ew_light = c_LIGHT_G;
      PH_EW_YELLOW: ew_light = c_LIGHT_Y;
      PH_FLASH: begin
        ns_light = flash_y_q ? c_LIGHT_Y : c_LIGHT_DARK;
        ew_light = flash_y_q ? c_LIGHT_Y : c_LIGHT_DARK;
      end
      default: begin
        ns_light = c_LIGHT_R;
        ew_light = c_LIGHT_R;
      end
    endcase
  end

  assign phase_id   = phase_q;
  assign time_left  = time_q;
  assign phase_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
// ============================================================================
// Module   : tb_traffic_phase_fsm
// Brief    : Scoreboard bench for traffic_phase_fsm. A behavioural model of
//            the phase rules predicts every cycle's outputs into a queue; a
//            monitor pops and compares after each rising edge.
//            Honours TLC_SENSOR_SYNC_EN by delaying detector inputs in the
//            model by two clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_fsm;

  localparam int TG = 30, TY = 3, TA = 2, TMIN = 10, TE = 5, TMAX = 60;

  logic       clk = 1'b0;
  logic       rst_n, tick, veh_ns, veh_ew;
  logic [1:0] mode_sel;
  logic [3:0] phase_id;
  logic [7:0] time_left;
  logic [2:0] ns_light, ew_light;
  logic       phase_done;

  traffic_phase_fsm #(
    .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA),
    .T_MIN_GREEN(TMIN), .T_EXT(TE), .T_MAX_GREEN(TMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode_sel(mode_sel),
    .veh_ns(veh_ns), .veh_ew(veh_ew), .phase_id(phase_id),
    .time_left(time_left), .ns_light(ns_light), .ew_light(ew_light),
    .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ph;
    logic [7:0] tl;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Observation counters gathered at negedges by the driver
  int n_done, n_done_nsg, n_green;

  // Reference model state: ring position 0..5, or 6 flash / 7 all-stop
  int m_ph, m_tl, m_el;
  bit m_fy, m_done;
  bit m_ns1, m_ns2, m_ew1, m_ew2;

  function automatic int dur(input int ph, input logic [1:0] m);
    if (ph % 3 == 0) return (m == 2'b01) ? TMIN : TG;
    if (ph % 3 == 1) return TY;
    return TA;
  endfunction

  function automatic logic [2:0] lamp(input int ph, input bit fy, input bit is_ns);
    int own_g;
    own_g = is_ns ? 0 : 3;
    if (ph == 6)         return fy ? 3'b010 : 3'b000;
    if (ph == own_g)     return 3'b001;
    if (ph == own_g + 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic exp_t model_out();
    exp_t r;
    r.ph   = 4'(m_ph);
    r.tl   = 8'(m_tl);
    r.ns   = lamp(m_ph, m_fy, 1'b1);
    r.ew   = lamp(m_ph, m_fy, 1'b0);
    r.done = m_done;
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 5; m_tl = TA; m_el = 0; m_fy = 1'b1; m_done = 1'b0;
    m_ns1 = 1'b0; m_ns2 = 1'b0; m_ew1 = 1'b0; m_ew2 = 1'b0;
  endtask

  task automatic model_step(input bit t, input logic [1:0] m, input bit vns, input bit vew);
    int old;
    bit rn, re, req;
    old = m_ph;
`ifdef TLC_SENSOR_SYNC_EN
    rn = m_ns2; re = m_ew2;
    m_ns2 = m_ns1; m_ns1 = vns;
    m_ew2 = m_ew1; m_ew1 = vew;
`else
    rn = vns; re = vew;
`endif
    if (m == 2'b10) begin
      if (m_ph != 6) begin m_ph = 6; m_tl = 0; m_fy = 1'b1; end
      else if (t) m_fy = ~m_fy;
    end else if (m == 2'b11) begin
      if (m_ph != 7) begin m_ph = 7; m_tl = 0; end
    end else if (m_ph >= 6) begin
      m_ph = 5; m_tl = TA;
    end else if (t) begin
      req = (m_ph == 0) ? rn : re;
      if (m_ph % 3 == 0) m_el = (m_el < 255) ? m_el + 1 : 255;
      if (m_tl > 1) m_tl = m_tl - 1;
      else if ((m_ph % 3 == 0) && (m == 2'b01) && req && (m_el + TE <= TMAX)) m_tl = TE;
      else begin
        m_ph = (m_ph + 1) % 6;
        m_tl = dur(m_ph, m);
        if (m_ph % 3 == 0) m_el = 0;
      end
    end
    m_done = (m_ph != old);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_phase"}, int'(phase_id), 5);
    chk({name, "_tl"}, int'(time_left), TA);
    chk({name, "_ns"}, int'(ns_light), 4);
    chk({name, "_ew"}, int'(ew_light), 4);
    chk({name, "_done"}, int'(phase_done), 0);
  endtask

  // One clk of stimulus: observe, drive, predict the next edge's outputs
  task automatic cyc(input bit t, input logic [1:0] m, input bit vns, input bit vew);
    @(negedge clk);
    if (phase_id == 4'd0 && t) n_green++;
    if (phase_done) begin
      n_done++;
      if (phase_id == 4'd0) n_done_nsg++;
    end
    tick = t; mode_sel = m; veh_ns = vns; veh_ew = vew;
    model_step(t, m, vns, vew);
    q.push_back(model_out());
  endtask

  // Tick after a random idle gap so ticks are never adjacent
  task automatic tk(input logic [1:0] m, input bit vns, input bit vew);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap + 1) cyc(1'b0, m, vns, vew);
    cyc(1'b1, m, vns, vew);
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0; tick = 1'b0; mode_sel = m; veh_ns = 1'b0; veh_ew = 1'b0;
    model_reset();
    #1 chk_reset("rst_hold");
    @(negedge clk);
    chk_reset("rst_clk");
    rst_n = 1'b1;
    n_done = 0; n_done_nsg = 0; n_green = 0;
    model_step(1'b0, m, 1'b0, 1'b0);
    q.push_back(model_out());
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: one prediction per rising edge, sampled 1 ns later
  always @(posedge clk) begin
    #1;
    if (mon_en && q.size() != 0) begin
      e_mon = q.pop_front();
      total++;
      if ({phase_id, time_left, ns_light, ew_light, phase_done} !== e_mon) begin
        bad++;
        $display("FAIL scoreboard t=%0t got ph=%0d tl=%0d ns=%b ew=%b pd=%b want ph=%0d tl=%0d ns=%b ew=%b pd=%b",
                 $time, phase_id, time_left, ns_light, ew_light, phase_done,
                 e_mon.ph, e_mon.tl, e_mon.ns, e_mon.ew, e_mon.done);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int budget;
    logic [1:0] rm;
    bit rvn, rve;
    rst_n = 1'b1; tick = 1'b0; mode_sel = 2'b00; veh_ns = 1'b0; veh_ew = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("por");

    // Fixed mode: 37 ticks walk ALLRED_B, NS green/yellow, ALLRED_A
    do_reset(2'b00);
    repeat (37) tk(2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("fixed37_phase", int'(phase_id), 3);
    chk("fixed37_tl", int'(time_left), TG);
    chk("fixed37_pulses", n_done, 4);

    // Actuated with NS demand held: green runs to the ceiling, no extra pulses
    do_reset(2'b01);
    budget = 0;
    while (m_ph != 1 && budget < 300) begin tk(2'b01, 1'b1, 1'($urandom_range(0, 1))); budget++; end
    chk("act_ext_budget", int'(budget < 300), 1);
    chk("act_ext_green_ticks", n_green, TMIN + TE * ((TMAX - TMIN) / TE));
    chk("act_ext_nsg_pulses", n_done_nsg, 1);

    // Actuated without NS demand: minimum green only
    do_reset(2'b01);
    budget = 0;
    while (m_ph != 1 && budget < 100) begin tk(2'b01, 1'b0, 1'($urandom_range(0, 1))); budget++; end
    chk("act_min_budget", int'(budget < 100), 1);
    chk("act_min_green_ticks", n_green, TMIN);

    // Flash from mid EW green, then back to fixed through clearance
    do_reset(2'b00);
    budget = 0;
    while (!(m_ph == 3 && m_tl == 12) && budget < 200) begin tk(2'b00, 1'b0, 1'b0); budget++; end
    chk("flash_reach_budget", int'(budget < 200), 1);
    cyc(1'b0, 2'b10, 1'b0, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b0);
    chk("flash_phase", int'(phase_id), 6);
    chk("flash_tl", int'(time_left), 0);
    chk("flash_first_y", int'(ns_light), 2);
    repeat (5) tk(2'b10, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("recover_phase", int'(phase_id), 5);
    chk("recover_tl", int'(time_left), TA);
    repeat (2) tk(2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("recover_nsg_phase", int'(phase_id), 0);
    chk("recover_nsg_tl", int'(time_left), TG);

    // Tick coincident with 00->11, landing on an expiring green
    do_reset(2'b00);
    budget = 0;
    while (!(m_ph == 0 && m_tl == 1) && budget < 100) begin tk(2'b00, 1'b0, 1'b0); budget++; end
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    n_done = 0;
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    repeat (5) cyc(1'($urandom_range(0, 1)), 2'b11, 1'b0, 1'b0);
    chk("stop_phase", int'(phase_id), 7);
    chk("stop_ns", int'(ns_light), 4);
    chk("stop_ew", int'(ew_light), 4);
    chk("stop_pulses", n_done, 1);

    // Randomized soak across all modes and detector patterns
    do_reset(2'b00);
    rm = 2'b00; rvn = 1'b0; rve = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rvn = ~rvn;
      if ($urandom_range(0, 19) == 0) rve = ~rve;
      if ($urandom_range(0, 2) == 0) cyc(1'b1, rm, rvn, rve);
      else cyc(1'b0, rm, rvn, rve);
    end

    // Asynchronous reset in the middle of NS yellow
    do_reset(2'b00);
    budget = 0;
    while (m_ph != 1 && budget < 100) begin tk(2'b00, 1'b0, 1'b0); budget++; end
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("async_pre_phase", int'(phase_id), 1);
    #3;
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1 chk_reset("async");
    do_reset(2'b00);
    repeat (3) tk(2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_phase_fsm.md
TRAFFIC_PHASE_FSM -- requirements
Module: traffic_phase_fsm

Interface
REQ-001 Parameter: T_GREEN, 30, fixed-mode green duration in ticks (1..99).
REQ-002 Parameter: T_YELLOW, 3, yellow duration in ticks (1..99).
REQ-003 Parameter: T_ALLRED, 2, all-red clearance duration in ticks (1..99).
REQ-004 Parameter: T_MIN_GREEN, 10, actuated-mode initial green in ticks (1..99).
REQ-005 Parameter: T_EXT, 5, actuated-mode extension per grant in ticks (1..99).
REQ-006 Parameter: T_MAX_GREEN, 60, actuated-mode green ceiling in ticks (T_MIN_GREEN..255).
REQ-007 Port: clk, input, 1, single system clock; all logic on its rising edge.
REQ-008 Port: rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-009 Port: tick, input, 1, one-clk-wide 1 Hz enable pulse.
REQ-010 Port: mode_sel, input, 2, 00 fixed, 01 actuated, 10 flash, 11 all-stop.
REQ-011 Port: veh_ns / veh_ew, input, 1 each, vehicle-present level from NS / EW detectors.
REQ-012 Port: phase_id, output, 4, 0 NS_GREEN, 1 NS_YELLOW, 2 ALLRED_A, 3 EW_GREEN, 4 EW_YELLOW, 5 ALLRED_B, 6 FLASH, 7 ALL_STOP.
REQ-013 Port: time_left, output, 8, remaining ticks of current phase (0..99).
REQ-014 Port: ns_light / ew_light, output, 3 each, one-hot {R,Y,G}; 000 = dark.
REQ-015 Port: phase_done, output, 1, one-clk pulse on each phase transition.

Function
REQ-016 Phase ring SHALL be NS_GREEN->NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->NS_GREEN in modes 00/01.
REQ-017 On phase entry time_left SHALL load the phase duration; each tick SHALL decrement it by 1.
REQ-018 A tick seen with time_left==1 SHALL advance the phase and load the next duration in the same clk; time_left SHALL never read 0 in modes 00/01.
REQ-019 Durations: GREEN = T_GREEN (00) or T_MIN_GREEN (01); YELLOW = T_YELLOW; ALLRED = T_ALLRED.
REQ-020 Actuated green expiry: if own-approach request is high and green_elapsed + T_EXT <= T_MAX_GREEN, reload time_left = T_EXT and stay; else advance.
REQ-021 green_elapsed SHALL be an 8-bit count of ticks since green entry, cleared on green entry, saturating at 255.
REQ-022 Lights: GREEN phase = that approach G, other R; YELLOW = that approach Y, other R; ALLRED/ALL_STOP = both R.
REQ-023 FLASH: phase_id = 6, time_left = 0, both lights toggle Y/dark on each tick, starting Y.
REQ-024 ALL_STOP: phase_id = 7, time_left = 0.
REQ-025 mode_sel entering 10 or 11 SHALL take effect on the next clk edge, regardless of tick.
REQ-026 mode_sel leaving 10/11 for 00/01 SHALL enter ALLRED_B with T_ALLRED, then NS_GREEN.
REQ-027 A change between 00 and 01 SHALL NOT interrupt the current phase; the new mode applies at the next duration load.
REQ-028 phase_done SHALL pulse for every phase_id change, including mode-forced changes, and for no other reason; extensions SHALL NOT pulse it.
REQ-029 A tick coincident with a mode change SHALL be consumed by the mode change only.

Reset
REQ-030 While rst_n is low: phase_id = 5 (ALLRED_B), time_left = T_ALLRED, ns_light = ew_light = 100, phase_done = 0, green_elapsed = 0, flash toggle = Y.
REQ-031 Reset assertion mid-phase SHALL abort the phase immediately (asynchronously); after release, the first tick SHALL decrement from T_ALLRED.

Configuration
REQ-032 Macro TLC_SENSOR_SYNC_EN defined: veh_ns/veh_ew SHALL pass through 2-flop synchronizers (2-clk latency), reset to 0.
REQ-033 Macro TLC_SENSOR_SYNC_EN undefined: veh_ns/veh_ew SHALL be used directly, 0-clk latency.

Structure
REQ-034 Package tlc_pkg SHALL hold mode codes, phase_id constants 0..7, and one-hot light constants.
REQ-035 Sub-module tlc_sync2 SHALL implement the 2-flop synchronizer, instantiated only under TLC_SENSOR_SYNC_EN.

Verification
REQ-036 Mode 00, reset release, 37 ticks -> ALLRED_B 2 ticks, NS_GREEN 30 (30..1), NS_YELLOW 3, ALLRED_A 2; one phase_done pulse per transition.
REQ-037 Mode 01, veh_ns held 1 -> NS_GREEN 10, then extensions of 5 up to 60 ticks total, then NS_YELLOW; no phase_done on extensions.
REQ-038 Mode 01, veh_ns 0 -> NS_GREEN lasts exactly 10 ticks.
REQ-039 Mid-EW_GREEN (time_left = 12) switch to 10 -> next clk phase_id = 6, time_left = 0, lights toggle Y/dark per tick; switch to 00 -> ALLRED_B 2 ticks, then NS_GREEN 30.
REQ-040 Tick coincident with the 00->11 change -> phase_id = 7, both R, a single phase_done pulse.
REQ-041 rst_n low mid-NS_YELLOW -> outputs equal the REQ-030 values without a clk edge.
